// File: rtl/bus_responder_pkg.sv
// Shared types and constants for the bus responder: FSM states, address regions,
// device register offsets and status bit positions.
package bus_responder_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, ACK} state_t;
  typedef enum logic [1:0] {ROM, DEV, RAM, NONE} region_t;

  localparam logic [2:0] OFF_ENTRY_LO = 3'd0;
  localparam logic [2:0] OFF_ENTRY_HI = 3'd1;
  localparam logic [2:0] OFF_GPIO_IN  = 3'd2;
  localparam logic [2:0] OFF_GPIO_OUT = 3'd3;
  localparam logic [2:0] OFF_GPIO_OE  = 3'd4;
  localparam logic [2:0] OFF_WAIT     = 3'd5;
  localparam logic [2:0] OFF_STATUS   = 3'd6;

  localparam int ST_UNMAPPED = 0;
  localparam int ST_ABORT    = 1;
  localparam int ST_ROMWR    = 2;

endpackage

// File: rtl/bus_responder_regs.sv
// Local register file: boot vector, GPIO, wait-state count and W1C error status.
// gpio_in is double-flopped before it can be read.
module bus_responder_regs
  import bus_responder_pkg::*;
#(
  parameter int         AW       = 16,
  parameter int         DW       = 8,
  parameter logic [2:0] WAIT_RST = 3'd0
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          i_wr_en,
  input  logic          i_rd_en,
  input  logic [2:0]    i_offset,
  input  logic [DW-1:0] i_wdata,
  input  logic [2:0]    i_err_set,
  input  logic [DW-1:0] i_gpio_in,
  output logic [DW-1:0] o_rdata,
  output logic [AW-1:0] o_entry,
  output logic [DW-1:0] o_gpio_out,
  output logic [DW-1:0] o_gpio_oe,
  output logic [2:0]    o_wait,
  output logic          o_err
);

  logic [DW-1:0] r_entry_lo, r_entry_hi, r_gpio_out, r_gpio_oe, r_sync1, r_sync2;
  logic [2:0]    r_wait, r_status;
  logic [2:0]    w_w1c;
  logic [DW-1:0] w_mux;

  assign w_w1c = (i_wr_en && i_offset == OFF_STATUS) ? i_wdata[2:0] : 3'b000;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_entry_lo <= '0;
      r_entry_hi <= '0;
      r_gpio_out <= '0;
      r_gpio_oe  <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_wait     <= WAIT_RST;
      r_status   <= 3'b000;
    end else begin
      r_sync1 <= i_gpio_in;
      r_sync2 <= r_sync1;
      if (i_wr_en) begin
        case (i_offset)
          OFF_ENTRY_LO: r_entry_lo <= i_wdata;
          OFF_ENTRY_HI: r_entry_hi <= i_wdata;
          OFF_GPIO_OUT: r_gpio_out <= i_wdata;
          OFF_GPIO_OE:  r_gpio_oe  <= i_wdata;
          OFF_WAIT:     r_wait     <= i_wdata[2:0];
          default: ;
        endcase
      end
      // A new error on a bit beats a clear of that bit in the same cycle.
      r_status <= (r_status & ~w_w1c) | i_err_set;
    end
  end

  always_comb begin
    w_mux = '0;
    case (i_offset)
      OFF_ENTRY_LO: w_mux = r_entry_lo;
      OFF_ENTRY_HI: w_mux = r_entry_hi;
      OFF_GPIO_IN:  w_mux = r_sync2;
      OFF_GPIO_OUT: w_mux = r_gpio_out;
      OFF_GPIO_OE:  w_mux = r_gpio_oe;
      OFF_WAIT:     w_mux = {{(DW-3){1'b0}}, r_wait};
      OFF_STATUS:   w_mux = {{(DW-3){1'b0}}, r_status};
      default:      w_mux = '0;
    endcase
  end

  assign o_rdata    = i_rd_en ? w_mux : '0;
  assign o_entry    = {r_entry_hi, r_entry_lo};
  assign o_gpio_out = r_gpio_out;
  assign o_gpio_oe  = r_gpio_oe;
  assign o_wait     = r_wait;
  assign o_err      = |r_status;

endmodule

// File: rtl/bus_responder.sv
// Target side of the 4-phase valid/ready bus: address decode, wait states,
// sync memory port sequencing and the handshake FSM.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int            AW       = 16,
  parameter int            DW       = 8,
  parameter logic [AW-1:0] ROM_TOP  = 'h0FF,
  parameter logic [AW-1:0] DEV_BASE = 'h100,
  parameter logic [AW-1:0] RAM_TOP  = 'h1FF,
  parameter int            MEM_LAT  = 1,
  parameter logic [2:0]    WAIT_RST = 3'd0
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          i_valid,
  input  logic          i_write,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic          o_ready,
  output logic [DW-1:0] o_rdata,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic [AW-1:0] o_entry,
  input  logic [DW-1:0] i_gpio_in,
  output logic [DW-1:0] o_gpio_out,
  output logic [DW-1:0] o_gpio_oe,
  output logic          o_err
);

  localparam int            LW      = $clog2(MEM_LAT + 1);
  localparam logic [AW-1:0] DEV_END = DEV_BASE + AW'(8);

  state_t        r_state;
  region_t       r_region;
  logic          r_write, r_ready, r_mem_en, r_mem_we;
  logic [2:0]    r_cnt;
  logic [LW-1:0] r_acnt;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata, r_rdata;

  region_t       w_region;
  logic          w_last, w_reg_wr, w_reg_rd;
  logic [2:0]    w_err_set, w_wait;
  logic [DW-1:0] w_reg_rdata;

  always_comb begin
    w_region = NONE;
    if (i_addr <= ROM_TOP)                          w_region = ROM;
    else if (i_addr >= DEV_BASE && i_addr < DEV_END) w_region = DEV;
    else if (i_addr >= DEV_END && i_addr <= RAM_TOP) w_region = RAM;
  end

  // Memory data lands MEM_LAT cycles after the strobe cycle, so commit one edge later.
  assign w_last   = (r_state == ACCESS) && i_valid && (r_acnt == LW'(MEM_LAT));
  assign w_reg_wr = w_last && (r_region == DEV) && r_write;
  assign w_reg_rd = w_last && (r_region == DEV) && !r_write;

  always_comb begin
    w_err_set              = 3'b000;
    w_err_set[ST_UNMAPPED] = w_last && (r_region == NONE);
    w_err_set[ST_ROMWR]    = w_last && (r_region == ROM) && r_write;
    w_err_set[ST_ABORT]    = !i_valid && (r_state == WAIT || r_state == ACCESS);
  end

  bus_responder_regs #(.AW(AW), .DW(DW), .WAIT_RST(WAIT_RST)) u_regs (
    .clk        (clk),
    .rstb       (rstb),
    .i_wr_en    (w_reg_wr),
    .i_rd_en    (w_reg_rd),
    .i_offset   (r_mem_addr[2:0]),
    .i_wdata    (r_mem_wdata),
    .i_err_set  (w_err_set),
    .i_gpio_in  (i_gpio_in),
    .o_rdata    (w_reg_rdata),
    .o_entry    (o_entry),
    .o_gpio_out (o_gpio_out),
    .o_gpio_oe  (o_gpio_oe),
    .o_wait     (w_wait),
    .o_err      (o_err)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= IDLE;
      r_region    <= NONE;
      r_write     <= 1'b0;
      r_ready     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_cnt       <= 3'd0;
      r_acnt      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      case (r_state)
        IDLE: if (i_valid) begin
          r_region    <= w_region;
          r_write     <= i_write;
          r_mem_addr  <= i_addr;
          r_mem_wdata <= i_wdata;
          r_cnt       <= w_wait;
          r_acnt      <= '0;
          if (w_wait != 3'd0) r_state <= WAIT;
          else begin
            r_state  <= ACCESS;
            r_mem_en <= (w_region == ROM) || (w_region == RAM);
            r_mem_we <= i_write && (w_region == RAM);
          end
        end
        WAIT: begin
          if (!i_valid) r_state <= IDLE;
          else begin
            r_cnt <= r_cnt - 3'd1;
            if (r_cnt == 3'd1) begin
              r_state  <= ACCESS;
              r_mem_en <= (r_region == ROM) || (r_region == RAM);
              r_mem_we <= r_write && (r_region == RAM);
            end
          end
        end
        ACCESS: begin
          if (!i_valid) r_state <= IDLE;
          else if (r_acnt == LW'(MEM_LAT)) begin
            r_state <= ACK;
            r_ready <= 1'b1;
            case (r_region)
              ROM, RAM: if (!r_write) r_rdata <= i_mem_rdata;
              DEV:      if (!r_write) r_rdata <= w_reg_rdata;
              default:  r_rdata <= '1;
            endcase
          end else r_acnt <= r_acnt + LW'(1);
        end
        ACK: if (!i_valid) begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_rdata     = r_rdata;
  assign o_mem_en    = r_mem_en;
  // A write strobe already issued is suppressed if the initiator has gone away.
  assign o_mem_we    = r_mem_we & i_valid;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule
